// File: rtl/bf16_div_seq.sv
// Sequential bfloat16 divider: radix-2 restoring division, one quotient bit per cycle,
// with round-to-nearest-even and a valid/ready handshake on both sides.
package ibex_pkg;
    typedef enum logic [3:0] {
        Zero, Neg_Zero, Subnormal, Neg_Subnormal, Normal, Neg_Normal, Inf, Neg_Inf, NaN
    } Classif_e;
endpackage

module bf16_div_seq (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [15:0]        rs1_i,
    input  logic [15:0]        rs2_i,
    input  ibex_pkg::Classif_e Classif_op_a,
    input  ibex_pkg::Classif_e Classif_op_b,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [15:0]        rd_o
);
    import ibex_pkg::*;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

    state_e             state;
    logic               sign;
    logic signed [9:0]  exp_q;
    logic [8:0]         rem_q;
    logic [8:0]         div_q;
    logic [9:0]         quo_q;
    logic [3:0]         cnt;

    assign ready_o = (state == IDLE) && !rst_i;

    // Special-case detection works on the live operands during the accept cycle.
    logic        sign_in;
    logic        nan_any, inf_a, inf_b, zero_a, zero_b;
    logic        special_hit;
    logic [15:0] special_val;

    assign sign_in = rs1_i[15] ^ rs2_i[15];
    assign nan_any = (Classif_op_a == NaN) || (Classif_op_b == NaN);
    assign inf_a   = (Classif_op_a == Inf) || (Classif_op_a == Neg_Inf);
    assign inf_b   = (Classif_op_b == Inf) || (Classif_op_b == Neg_Inf);
    assign zero_a  = (rs1_i[14:0] == 15'h0000);
    assign zero_b  = (rs2_i[14:0] == 15'h0000);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        special_hit = 1'b1;
        special_val = 16'h7FC0;
        if (nan_any || (inf_a && inf_b) || (zero_a && zero_b))
            special_val = 16'h7FC0;
        else if (inf_a || zero_b)
            special_val = {sign_in, 15'h7F80};
        else if (inf_b || zero_a)
            special_val = {sign_in, 15'h0000};
        else
            special_hit = 1'b0;
    end

    // One restoring step: the remainder stays below 2*D, so 9 bits suffice.
    logic       ge;
    logic [8:0] diff;
    logic [8:0] rem_nx;
    logic [9:0] quo_nx;

    assign ge     = (rem_q >= div_q);
    assign diff   = ge ? (rem_q - div_q) : rem_q;
    assign rem_nx = {diff[7:0], 1'b0};
    assign quo_nx = {quo_q[8:0], ge};

    // Normalise, round to nearest even, then range-check the final quotient.
    logic signed [9:0] e_adj;
    logic [6:0]        mant;
    logic              rnd;
    logic              sticky;
    logic [7:0]        mant_inc;
    logic [15:0]       result;

    always_comb begin
        e_adj = exp_q;
        if (quo_nx[9]) begin
            mant   = quo_nx[8:2];
            rnd    = quo_nx[1];
            sticky = quo_nx[0] | (rem_nx != 9'd0);
        end else begin
            mant   = quo_nx[7:1];
            rnd    = quo_nx[0];
            sticky = (rem_nx != 9'd0);
            e_adj  = exp_q - 10'sd1;
        end
        mant_inc = {1'b0, mant} + {7'd0, rnd & (sticky | mant[0])};
        if (mant_inc[7])
            e_adj = e_adj + 10'sd1;
        if (e_adj >= 10'sd255)
            result = {sign, 15'h7F80};
        else if (e_adj <= 10'sd0)
            result = {sign, 15'h0000};
        else
            result = {sign, e_adj[7:0], mant_inc[6:0]};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            rd_o    <= 16'h0000;
            cnt     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        sign  <= sign_in;
                        exp_q <= $signed({2'b00, rs1_i[14:7]}) - $signed({2'b00, rs2_i[14:7]}) + 10'sd127;
                        if (special_hit) begin
                            rd_o  <= special_val;
                            state <= DONE;
                        end else begin
                            rem_q <= {2'b01, rs1_i[6:0]};
                            div_q <= {2'b01, rs2_i[6:0]};
                            quo_q <= 10'd0;
                            cnt   <= 4'd0;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        rd_o  <= result;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The result is only consumed once valid_o is actually visible.
                    if (valid_o && ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        valid_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_div_seq.sv
// Self-checking bench for bf16_div_seq: directed cases plus randomized operands
// compared against an arithmetic bfloat16 division model.
module tb_bf16_div_seq;
    import ibex_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [15:0] rs1 = 16'h0000;
    logic [15:0] rs2 = 16'h0000;
    Classif_e    cls_a;
    Classif_e    cls_b;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [15:0] rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic Classif_e classify(input logic [15:0] x);
        if (x[14:7] == 8'hFF)
            return (x[6:0] != 7'd0) ? NaN : (x[15] ? Neg_Inf : Inf);
        if (x[14:0] == 15'd0)
            return x[15] ? Neg_Zero : Zero;
        if (x[14:7] == 8'h00)
            return x[15] ? Neg_Subnormal : Subnormal;
        return x[15] ? Neg_Normal : Normal;
    endfunction

    assign cls_a = classify(rs1);
    assign cls_b = classify(rs2);

    bf16_div_seq dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid_in),
        .ready_o      (ready_out),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .Classif_op_a (cls_a),
        .Classif_op_b (cls_b),
        .valid_o      (valid_out),
        .ready_i      (ready_in),
        .rd_o         (rd)
    );

    // Reference: exact integer quotient of the significands, then normalise and round.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, output bit special);
        int ea, eb, sa, sb, num, q, rem, e, mant, rnd, st;
        bit sg, nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        sg    = a[15] ^ b[15];
        ea    = int'(a[14:7]);
        eb    = int'(b[14:7]);
        nan_a = (ea == 255) && (a[6:0] != 0);
        nan_b = (eb == 255) && (b[6:0] != 0);
        inf_a = (ea == 255) && (a[6:0] == 0);
        inf_b = (eb == 255) && (b[6:0] == 0);
        z_a   = (a[14:0] == 0);
        z_b   = (b[14:0] == 0);
        special = 1'b1;
        if (nan_a || nan_b || (inf_a && inf_b) || (z_a && z_b)) return 16'h7FC0;
        if (inf_a || z_b) return {sg, 15'h7F80};
        if (inf_b || z_a) return {sg, 15'h0000};
        special = 1'b0;
        sa  = 128 + int'(a[6:0]);
        sb  = 128 + int'(b[6:0]);
        num = sa * 512;
        q   = num / sb;
        rem = num % sb;
        e   = ea - eb + 127;
        if (q >= 512) begin
            mant = (q / 4) % 128;
            rnd  = (q / 2) % 2;
            st   = ((q % 2) != 0 || rem != 0) ? 1 : 0;
        end else begin
            mant = (q / 2) % 128;
            rnd  = q % 2;
            st   = (rem != 0) ? 1 : 0;
            e    = e - 1;
        end
        if (rnd == 1 && (st == 1 || (mant % 2) == 1)) mant = mant + 1;
        if (mant == 128) begin
            mant = 0;
            e    = e + 1;
        end
        if (e >= 255) return {sg, 15'h7F80};
        if (e <= 0)   return {sg, 15'h0000};
        return {sg, e[7:0], mant[6:0]};
    endfunction

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, measure latency, compare result; optionally complete the handshake.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] expected, input int exp_lat, input bit finish);
        int  n;
        int  lat;
        bit  busy_ok;
        n = 0;
        while (!ready_out && n < 30) begin
            step();
            n++;
        end
        check({tag, "_ready"}, {15'd0, ready_out}, 16'd1);
        rs1 = a;
        rs2 = b;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!valid_out && lat < 30) begin
            if (ready_out) busy_ok = 1'b0;
            step();
            lat++;
        end
        check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
        check({tag, "_busy"}, {15'd0, busy_ok}, 16'd1);
        check({tag, "_rd"}, rd, expected);
        if (finish) begin
            ready_in = 1'b1;
            step();
            check({tag, "_drop"}, {14'd0, valid_out, ready_out}, 16'b01);
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_val;
        bit          sp;

        repeat (2) step();
        check("reset_state", {rd[13:0], valid_out, ready_out}, 16'h0000);
        rst = 1'b0;
        #0;
        check("reset_ready", {15'd0, ready_out}, 16'd1);
        step();

        run_op("one_div_one", 16'h3F80, 16'h3F80, 16'h3F80, 11, 1);
        run_op("six_div_two", 16'h40C0, 16'h4000, 16'h4040, 11, 1);
        run_op("third",       16'h3F80, 16'h4040, 16'h3EAB, 11, 1);
        run_op("neg_third",   16'hBF80, 16'h4040, 16'hBEAB, 11, 1);
        run_op("inf_inf",     16'h7F80, 16'h7F80, 16'h7FC0, 1, 1);
        run_op("neg_by_zero", 16'hBF80, 16'h0000, 16'hFF80, 1, 1);
        run_op("zero_zero",   16'h0000, 16'h0000, 16'h7FC0, 1, 1);
        run_op("one_by_inf",  16'h3F80, 16'h7F80, 16'h0000, 1, 1);
        run_op("nan_op",      16'h7FC1, 16'h3F80, 16'h7FC0, 1, 1);
        run_op("overflow",    16'h7F00, 16'h3F00, 16'h7F80, 11, 1);
        run_op("underflow",   16'h0080, 16'h4300, 16'h0000, 11, 1);

        // Backpressure with a stray valid pulse while busy.
        ready_in = 1'b0;
        rs1 = 16'h40C0;
        rs2 = 16'h4000;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        repeat (3) step();
        rs1 = 16'h3F80;
        rs2 = 16'h4040;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 30 && !valid_out; i++) step();
        check("bp_valid", {15'd0, valid_out}, 16'd1);
        check("bp_rd", rd, 16'h4040);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold", {rd[14:0], valid_out}, {15'h4040 & 15'h7FFF, 1'b1});
        end
        ready_in = 1'b1;
        step();
        check("bp_release", {14'd0, valid_out, ready_out}, 16'b01);
        repeat (14) step();
        check("bp_no_extra", {15'd0, valid_out}, 16'd0);

        // Reset in the middle of a division.
        rs1 = 16'h40C0;
        rs2 = 16'h4000;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #0;
        check("rst_mid_state", {rd[13:0], valid_out, ready_out}, 16'h0001);
        check("rst_mid_rd", rd, 16'h0000);
        repeat (15) step();
        check("rst_no_result", {15'd0, valid_out}, 16'd0);
        run_op("after_reset", 16'h3F80, 16'h4040, 16'h3EAB, 11, 1);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            a[14:7] = 8'($urandom_range(96, 158));
            b[14:7] = 8'($urandom_range(96, 158));
            if ($urandom_range(0, 11) == 0) a[14:7] = 8'hFF;
            if ($urandom_range(0, 11) == 0) b[14:7] = 8'hFF;
            if ($urandom_range(0, 13) == 0) a[14:0] = 15'd0;
            if ($urandom_range(0, 13) == 0) b[14:0] = 15'd0;
            if ($urandom_range(0, 13) == 0) a[14:7] = 8'h00;
            exp_val = model(a, b, sp);
            run_op("random", a, b, exp_val, sp ? 1 : 11, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
